neuron_weight_seq: RTL and testbench

//  Sequencer/owner of one neuron's weight RAM (1R1W, registered read, 1-cycle latency).

---
 rtl/neuron_weight_seq.sv | 115 +++++++++++
 tb/tb_neuron_weight_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_weight_seq.sv
// Weight-RAM sequencer for one neuron: streams config words into the RAM (LOAD),
// then replays weights 0..NUM_WEIGHTS-1 alongside input samples to the MAC (RUN).
module neuron_weight_seq #(
    parameter int DATA_SIZE   = 9,
    parameter int ADDR_SIZE   = 9,
    parameter int NUM_WEIGHTS = 784,
    parameter bit PRELOADED   = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_req_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [DATA_SIZE:0]   cfg_data_i,
    input  logic                 start_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DATA_SIZE:0]   in_data_i,
    output logic                 rom_w_en_o,
    output logic [ADDR_SIZE:0]   rom_w_addr_o,
    output logic [DATA_SIZE:0]   rom_w_data_o,
    output logic                 rom_r_en_o,
    output logic [ADDR_SIZE:0]   rom_r_addr_o,
    input  logic [DATA_SIZE:0]   rom_rdata_i,
    output logic                 mac_valid_o,
    output logic [DATA_SIZE:0]   mac_weight_o,
    output logic [DATA_SIZE:0]   mac_x_o,
    output logic                 mac_last_o,
    output logic                 busy_o,
    output logic                 load_done_o,
    output logic                 done_o
);

    typedef enum logic [2:0] {IDLE, READY, LOAD, RUN, DRAIN} state_t;

    localparam logic [ADDR_SIZE:0] CNT_LAST = NUM_WEIGHTS[ADDR_SIZE:0] - 1'b1;

    state_t               state_q;
    logic [ADDR_SIZE:0]   cnt_q;
    logic                 mac_valid_q;
    logic                 mac_last_q;
    logic [DATA_SIZE:0]   mac_x_q;
    logic                 load_done_q;
    logic                 done_q;

    logic cfg_hs, in_hs, cnt_last;

    assign cfg_hs   = (state_q == LOAD) && cfg_valid_i;
    assign in_hs    = (state_q == RUN) && in_valid_i;
    assign cnt_last = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= PRELOADED ? READY : IDLE;
            cnt_q       <= '0;
            mac_valid_q <= 1'b0;
            mac_last_q  <= 1'b0;
            mac_x_q     <= '0;
            load_done_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            done_q      <= 1'b0;
            // RAM read has 1-cycle latency, so the sample and last flag ride one stage behind
            mac_valid_q <= in_hs;
            mac_last_q  <= in_hs && cnt_last;
            if (in_hs)
                mac_x_q <= in_data_i;
            if ((cfg_hs || in_hs) && !cnt_last)
                cnt_q <= cnt_q + 1'b1;
            case (state_q)
                IDLE: if (load_req_i) begin
                    state_q <= LOAD;
                    cnt_q   <= '0;
                end
                READY: if (load_req_i) begin
                    state_q <= LOAD;
                    cnt_q   <= '0;
                end else if (start_i) begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end
                LOAD: if (cfg_hs && cnt_last) begin
                    state_q     <= READY;
                    load_done_q <= 1'b1;
                end
                RUN: if (in_hs && cnt_last)
                    state_q <= DRAIN;
                DRAIN: begin
                    state_q <= READY;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_ready_o  = (state_q == LOAD);
    assign in_ready_o   = (state_q == RUN);
    assign busy_o       = (state_q == LOAD) || (state_q == RUN) || (state_q == DRAIN);

    assign rom_w_en_o   = cfg_hs;
    assign rom_w_addr_o = cfg_hs ? cnt_q : '0;
    assign rom_w_data_o = cfg_hs ? cfg_data_i : '0;
    assign rom_r_en_o   = in_hs;
    assign rom_r_addr_o = in_hs ? cnt_q : '0;

    assign mac_valid_o  = mac_valid_q;
    assign mac_weight_o = rom_rdata_i;
    assign mac_x_o      = mac_x_q;
    assign mac_last_o   = mac_valid_q && mac_last_q;
    assign load_done_o  = load_done_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_neuron_weight_seq.sv
// Directed bench for neuron_weight_seq: cycle table on a PRELOADED=0 instance,
// plus a hand sequence on a PRELOADED=1 instance for reset-mid-RUN.
module tb_neuron_weight_seq;

    localparam int DS = 7;
    localparam int AS = 3;
    localparam int NW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: PRELOADED=0
    logic       rst, load_req, cfg_valid, start, in_valid;
    logic [7:0] cfg_data, in_data;
    logic       cfg_ready, in_ready, rom_w_en, rom_r_en, mac_valid, mac_last, busy, load_done, done;
    logic [3:0] rom_w_addr, rom_r_addr;
    logic [7:0] rom_w_data, rom_rdata, mac_weight, mac_x;

    // instance 1: PRELOADED=1
    logic       rst1, start1, in_valid1;
    logic [7:0] in_data1;
    logic       cfg_ready1, in_ready1, rom_w_en1, rom_r_en1, mac_valid1, mac_last1, busy1, load_done1, done1;
    logic [3:0] rom_w_addr1, rom_r_addr1;
    logic [7:0] rom_w_data1, rom_rdata1, mac_weight1, mac_x1;

    neuron_weight_seq #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .NUM_WEIGHTS(NW), .PRELOADED(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .load_req_i(load_req), .cfg_valid_i(cfg_valid),
        .cfg_ready_o(cfg_ready), .cfg_data_i(cfg_data), .start_i(start), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_data_i(in_data), .rom_w_en_o(rom_w_en), .rom_w_addr_o(rom_w_addr),
        .rom_w_data_o(rom_w_data), .rom_r_en_o(rom_r_en), .rom_r_addr_o(rom_r_addr),
        .rom_rdata_i(rom_rdata), .mac_valid_o(mac_valid), .mac_weight_o(mac_weight),
        .mac_x_o(mac_x), .mac_last_o(mac_last), .busy_o(busy), .load_done_o(load_done), .done_o(done));

    neuron_weight_seq #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .NUM_WEIGHTS(NW), .PRELOADED(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst1), .load_req_i(1'b0), .cfg_valid_i(1'b0),
        .cfg_ready_o(cfg_ready1), .cfg_data_i(8'h00), .start_i(start1), .in_valid_i(in_valid1),
        .in_ready_o(in_ready1), .in_data_i(in_data1), .rom_w_en_o(rom_w_en1), .rom_w_addr_o(rom_w_addr1),
        .rom_w_data_o(rom_w_data1), .rom_r_en_o(rom_r_en1), .rom_r_addr_o(rom_r_addr1),
        .rom_rdata_i(rom_rdata1), .mac_valid_o(mac_valid1), .mac_weight_o(mac_weight1),
        .mac_x_o(mac_x1), .mac_last_o(mac_last1), .busy_o(busy1), .load_done_o(load_done1), .done_o(done1));

    // 1R1W RAM with registered read for instance 0; instance 1 holds A0+addr
    logic [7:0] mem [0:15];
    always @(posedge clk) begin
        if (rom_w_en) mem[rom_w_addr] <= rom_w_data;
        if (rom_r_en) rom_rdata <= mem[rom_r_addr];
        if (rom_r_en1) rom_rdata1 <= 8'hA0 + {4'h0, rom_r_addr1};
    end

    wire [8:0] fl0 = {cfg_ready, in_ready, rom_w_en, rom_r_en, busy, load_done, done, mac_valid, mac_last};
    wire [8:0] fl1 = {cfg_ready1, in_ready1, rom_w_en1, rom_r_en1, busy1, load_done1, done1, mac_valid1, mac_last1};

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // flags order: {cfg_ready,in_ready,w_en}_{r_en,busy,load_done}_{done,mac_valid,mac_last}
    typedef struct {
        logic       lr, cv, st, iv;
        logic [7:0] cd, id;
        logic [8:0] fl;
        logic [3:0] addr;
        logic [7:0] mw, mx;
    } vec_t;

    function automatic vec_t V(input logic lr, cv, input logic [7:0] cd, input logic st, iv,
                               input logic [7:0] id, input logic [8:0] fl, input logic [3:0] addr,
                               input logic [7:0] mw, mx);
        vec_t v;
        v.lr = lr; v.cv = cv; v.cd = cd; v.st = st; v.iv = iv; v.id = id;
        v.fl = fl; v.addr = addr; v.mw = mw; v.mx = mx;
        return v;
    endfunction

    task automatic drive1(input logic r, s, iv, input logic [7:0] d);
        @(posedge clk); #1;
        rst1 = r; start1 = s; in_valid1 = iv; in_data1 = d;
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[$];
        rst = 1'b1; load_req = 0; cfg_valid = 0; start = 0; in_valid = 0; cfg_data = 0; in_data = 0;
        rst1 = 1'b1; start1 = 0; in_valid1 = 0; in_data1 = 0;

        //            lr cv cd     st iv id     flags           addr  mw     mx
        tbl.push_back(V(0, 0, 8'h00, 1, 0, 8'h00, 9'b000_000_000, 4'd0, 8'h00, 8'h00)); // start in IDLE
        tbl.push_back(V(1, 0, 8'h00, 0, 0, 8'h00, 9'b000_000_000, 4'd0, 8'h00, 8'h00));
        tbl.push_back(V(0, 1, 8'h11, 0, 0, 8'h00, 9'b101_010_000, 4'd0, 8'h00, 8'h00));
        tbl.push_back(V(0, 0, 8'h00, 0, 0, 8'h00, 9'b100_010_000, 4'd0, 8'h00, 8'h00));
        tbl.push_back(V(0, 1, 8'h22, 0, 0, 8'h00, 9'b101_010_000, 4'd1, 8'h00, 8'h00));
        tbl.push_back(V(0, 1, 8'h33, 0, 0, 8'h00, 9'b101_010_000, 4'd2, 8'h00, 8'h00));
        tbl.push_back(V(0, 0, 8'h00, 0, 0, 8'h00, 9'b100_010_000, 4'd0, 8'h00, 8'h00));
        tbl.push_back(V(0, 1, 8'h44, 0, 0, 8'h00, 9'b101_010_000, 4'd3, 8'h00, 8'h00));
        tbl.push_back(V(0, 0, 8'h00, 0, 0, 8'h00, 9'b000_001_000, 4'd0, 8'h00, 8'h00)); // load_done
        tbl.push_back(V(0, 0, 8'h00, 1, 0, 8'h00, 9'b000_000_000, 4'd0, 8'h00, 8'h00));
        tbl.push_back(V(0, 0, 8'h00, 1, 1, 8'h01, 9'b010_110_000, 4'd0, 8'h00, 8'h00)); // start in RUN
        tbl.push_back(V(0, 0, 8'h00, 0, 1, 8'h02, 9'b010_110_010, 4'd1, 8'h11, 8'h01));
        tbl.push_back(V(0, 0, 8'h00, 0, 1, 8'h03, 9'b010_110_010, 4'd2, 8'h22, 8'h02));
        tbl.push_back(V(0, 0, 8'h00, 0, 1, 8'h04, 9'b010_110_010, 4'd3, 8'h33, 8'h03));
        tbl.push_back(V(0, 0, 8'h00, 0, 0, 8'h00, 9'b000_010_011, 4'd0, 8'h44, 8'h04)); // DRAIN
        tbl.push_back(V(0, 0, 8'h00, 0, 0, 8'h00, 9'b000_000_100, 4'd0, 8'h00, 8'h00)); // done
        tbl.push_back(V(0, 0, 8'h00, 0, 0, 8'h00, 9'b000_000_000, 4'd0, 8'h00, 8'h00));
        tbl.push_back(V(0, 0, 8'h00, 1, 0, 8'h00, 9'b000_000_000, 4'd0, 8'h00, 8'h00)); // gapped run
        tbl.push_back(V(0, 0, 8'h00, 0, 1, 8'h05, 9'b010_110_000, 4'd0, 8'h00, 8'h00));
        tbl.push_back(V(0, 0, 8'h00, 0, 0, 8'h00, 9'b010_010_010, 4'd0, 8'h11, 8'h05));
        tbl.push_back(V(0, 0, 8'h00, 0, 0, 8'h00, 9'b010_010_000, 4'd0, 8'h00, 8'h00));
        tbl.push_back(V(0, 0, 8'h00, 0, 1, 8'h06, 9'b010_110_000, 4'd1, 8'h00, 8'h00));
        tbl.push_back(V(0, 0, 8'h00, 0, 1, 8'h07, 9'b010_110_010, 4'd2, 8'h22, 8'h06));
        tbl.push_back(V(0, 0, 8'h00, 0, 0, 8'h00, 9'b010_010_010, 4'd0, 8'h33, 8'h07));
        tbl.push_back(V(0, 0, 8'h00, 0, 1, 8'h08, 9'b010_110_000, 4'd3, 8'h00, 8'h00));
        tbl.push_back(V(0, 0, 8'h00, 0, 0, 8'h00, 9'b000_010_011, 4'd0, 8'h44, 8'h08));
        tbl.push_back(V(0, 0, 8'h00, 0, 0, 8'h00, 9'b000_000_100, 4'd0, 8'h00, 8'h00));
        tbl.push_back(V(1, 0, 8'h00, 1, 0, 8'h00, 9'b000_000_000, 4'd0, 8'h00, 8'h00)); // load_req wins
        tbl.push_back(V(0, 0, 8'h00, 0, 1, 8'h09, 9'b100_010_000, 4'd0, 8'h00, 8'h00)); // no read in LOAD
        tbl.push_back(V(0, 1, 8'h55, 0, 0, 8'h00, 9'b101_010_000, 4'd0, 8'h00, 8'h00));
        tbl.push_back(V(0, 1, 8'h66, 0, 0, 8'h00, 9'b101_010_000, 4'd1, 8'h00, 8'h00));
        tbl.push_back(V(0, 1, 8'h77, 0, 0, 8'h00, 9'b101_010_000, 4'd2, 8'h00, 8'h00));
        tbl.push_back(V(0, 1, 8'h88, 0, 0, 8'h00, 9'b101_010_000, 4'd3, 8'h00, 8'h00));
        tbl.push_back(V(0, 0, 8'h00, 0, 0, 8'h00, 9'b000_001_000, 4'd0, 8'h00, 8'h00));
        tbl.push_back(V(0, 0, 8'h00, 1, 0, 8'h00, 9'b000_000_000, 4'd0, 8'h00, 8'h00));
        tbl.push_back(V(0, 0, 8'h00, 0, 1, 8'h0A, 9'b010_110_000, 4'd0, 8'h00, 8'h00));
        tbl.push_back(V(0, 0, 8'h00, 0, 0, 8'h00, 9'b010_010_010, 4'd0, 8'h55, 8'h0A)); // reloaded data

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset0_outputs", {fl0, rom_w_addr, rom_r_addr, rom_w_data, mac_x}, 32'h0);
        chk("reset1_outputs", {fl1, rom_w_addr1, rom_r_addr1, rom_w_data1, mac_x1}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; rst1 = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            if (i != 0) begin
                @(posedge clk); #1;
            end
            load_req = tbl[i].lr; cfg_valid = tbl[i].cv; cfg_data = tbl[i].cd;
            start = tbl[i].st; in_valid = tbl[i].iv; in_data = tbl[i].id;
            @(negedge clk);
            chk($sformatf("vec%0d_flags", i), fl0, tbl[i].fl);
            if (tbl[i].fl[6])
                chk($sformatf("vec%0d_waddr_wdata", i), {rom_w_addr, rom_w_data}, {tbl[i].addr, tbl[i].cd});
            if (tbl[i].fl[5])
                chk($sformatf("vec%0d_raddr", i), rom_r_addr, tbl[i].addr);
            if (tbl[i].fl[1])
                chk($sformatf("vec%0d_mac_pair", i), {mac_weight, mac_x}, {tbl[i].mw, tbl[i].mx});
        end

        // PRELOADED=1 instance: READY after reset, start accepted, reset mid-RUN abandons the pass
        drive1(0, 0, 0, 8'h00);
        chk("pre_ready_idle", fl1, 9'b000_000_000);
        drive1(0, 1, 0, 8'h00);
        chk("pre_start_cycle", fl1, 9'b000_000_000);
        drive1(0, 0, 1, 8'h01);
        chk("pre_run_s0", {fl1, rom_r_addr1}, {9'b010_110_000, 4'd0});
        drive1(0, 0, 1, 8'h02);
        chk("pre_run_s1", {fl1, rom_r_addr1, mac_weight1, mac_x1}, {9'b010_110_010, 4'd1, 8'hA0, 8'h01});
        drive1(1, 0, 0, 8'h00);
        chk("pre_rst_cycle", {fl1, mac_weight1, mac_x1}, {9'b010_010_010, 8'hA1, 8'h02});
        drive1(0, 0, 0, 8'h00);
        chk("pre_after_rst", {fl1, rom_r_addr1, rom_w_addr1, rom_w_data1, mac_x1}, 32'h0);
        drive1(0, 0, 0, 8'h00);
        chk("pre_no_done", fl1, 9'b000_000_000);
        drive1(0, 1, 0, 8'h00);
        chk("pre_restart", fl1, 9'b000_000_000);
        drive1(0, 0, 1, 8'h03);
        chk("pre_restart_addr0", {fl1, rom_r_addr1}, {9'b010_110_000, 4'd0});
        drive1(0, 0, 0, 8'h00);
        chk("pre_restart_pair", {fl1, mac_weight1, mac_x1}, {9'b010_010_010, 8'hA0, 8'h03});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
